// File: rtl/btn_step_gen.sv
// -----------------------------------------------------------------------------
// btn_step_gen
//
// Purpose:
//   Front end for the flip-flop lab. Turns a raw, bouncing push-button into a
//   clean one-clock "step" pulse so the downstream storage elements advance
//   exactly once per physical press. The switch bank is captured on each step,
//   and accepted presses are counted for display.
//
// Ports:
//   clk          in   1        system clock, all state on the rising edge
//   reset        in   1        asynchronous, active-high reset
//   btn_raw      in   1        raw push-button (asynchronous, bounces)
//   sw           in   4        raw switches (asynchronous)
//   step         out  1        one-cycle pulse per accepted press
//   btn_level    out  1        debounced button level
//   sw_latched   out  4        switch value captured with the last step
//   press_count  out  PRESS_W  accepted presses, modulo 2^PRESS_W
//   fsm_state    out  2        current debounce state, for observation only
//
// Parameters:
//   DEBOUNCE_CYCLES  stable-level cycles needed to accept a press or release
//                    (>= 2)
//   CNT_W            debounce counter width, must hold DEBOUNCE_CYCLES-1
//   PRESS_W          press counter width
// -----------------------------------------------------------------------------
module btn_step_gen #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17,
  parameter int PRESS_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_raw,
  input  logic [3:0]         sw,
  output logic               step,
  output logic               btn_level,
  output logic [3:0]         sw_latched,
  output logic [PRESS_W-1:0] press_count,
  output logic [1:0]         fsm_state
);

  // Debounce states. HELD and RELEASE_WAIT both mean "button is down".
  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  // Terminal count of the debounce counter.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers. Only btn_s / sw_s are used past this point; the
  // raw pins are never sampled anywhere else.
  // ---------------------------------------------------------------------------
  logic       btn_meta;
  logic       btn_s;
  logic [3:0] sw_meta;
  logic [3:0] sw_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      sw_meta  <= 4'h0;
      sw_s     <= 4'h0;
    end else begin
      btn_meta <= btn_raw;
      btn_s    <= btn_meta;
      sw_meta  <= sw;
      sw_s     <= sw_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;     // PRESS_WAIT -> HELD on this edge

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;

    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
        end
      end

      PRESS_WAIT: begin
        // Any low sample during the wait is treated as bounce: start over.
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      HELD: begin
        if (!btn_s) begin
          state_nxt = RELEASE_WAIT;
        end
      end

      RELEASE_WAIT: begin
        // A high sample here is release bounce; going back to HELD never
        // produces another step because steps only come from PRESS_WAIT.
        if (btn_s) begin
          state_nxt = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Every state change restarts the stability window.
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. step, sw_latched and press_count all update on the
  // accepting edge, so the latched switches and the count are already valid
  // in the cycle where step is high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step        <= 1'b0;
      btn_level   <= 1'b0;
      sw_latched  <= 4'h0;
      press_count <= '0;
    end else begin
      step      <= accept;
      btn_level <= (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
      if (accept) begin
        sw_latched  <= sw_s;
        press_count <= press_count + 1'b1;   // wraps silently
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_btn_step_gen.sv
// -----------------------------------------------------------------------------
// tb_btn_step_gen
//
// Directed and randomised stimulus for btn_step_gen with DEBOUNCE_CYCLES=4.
// The reference model treats the debouncer as a run-length filter: the
// debounced level flips once the synchronised button has disagreed with it
// for DEBOUNCE_CYCLES+1 consecutive edges; a 0->1 flip is a step.
// -----------------------------------------------------------------------------
module tb_btn_step_gen;

  localparam int D  = 4;
  localparam int PW = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset;
  logic          btn_raw;
  logic [3:0]    sw;
  logic          step;
  logic          btn_level;
  logic [3:0]    sw_latched;
  logic [PW-1:0] press_count;
  logic [1:0]    fsm_state;

  always #5 clk = ~clk;

  btn_step_gen #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3),
    .PRESS_W        (PW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .sw         (sw),
    .step       (step),
    .btn_level  (btn_level),
    .sw_latched (sw_latched),
    .press_count(press_count),
    .fsm_state  (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Counters, scoreboard, reference model state
  // ---------------------------------------------------------------------------
  int compared   = 0;
  int mismatched = 0;

  logic [PW+3:0] exp_q[$];   // {press_count, sw_latched} per expected step

  logic          m_s1, m_s;
  logic [3:0]    m_sw1, m_sw_s;
  logic          m_level, m_step;
  int            m_run;
  logic [PW-1:0] m_press;
  logic [3:0]    m_swl;

  int   edge_no;
  int   step_seen;
  int   last_step_edge;
  int   level_fall_edge;
  logic prev_level;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s = 1'b0; m_sw1 = 4'h0; m_sw_s = 4'h0;
    m_level = 1'b0; m_step = 1'b0; m_run = 0;
    m_press = '0; m_swl = 4'h0;
    exp_q.delete();
  endtask

  // One rising edge of the reference: filter uses the already-synchronised
  // sample, then the synchroniser pipeline shifts in the pins.
  task automatic model_edge();
    m_step = 1'b0;
    if (m_s != m_level) begin
      m_run++;
      if (m_run == D + 1) begin
        m_level = ~m_level;
        m_run   = 0;
        if (m_level) begin
          m_step  = 1'b1;
          m_press = m_press + 1'b1;
          m_swl   = m_sw_s;
          exp_q.push_back({m_press, m_swl});
        end
      end
    end else begin
      m_run = 0;
    end
    m_s    = m_s1;
    m_s1   = btn_raw;
    m_sw_s = m_sw1;
    m_sw1  = sw;
  endtask

  task automatic compare_outputs();
    logic [PW+3:0] rec;
    check("step",        step,        m_step);
    check("btn_level",   btn_level,   m_level);
    check("press_count", press_count, m_press);
    check("sw_latched",  sw_latched,  m_swl);
    if (step === 1'b1) begin
      step_seen++;
      last_step_edge = edge_no;
      if (exp_q.size() > 0) begin
        rec = exp_q.pop_front();
        check("sb_step_record", {press_count, sw_latched}, rec);
      end else begin
        check("sb_unexpected_step", step, 1'b0);
      end
    end
    if (prev_level === 1'b1 && btn_level === 1'b0) level_fall_edge = edge_no;
    prev_level = btn_level;
  endtask

  // Drive pins away from the edge, take one edge, check 1 time unit later.
  task automatic tick(input logic b, input logic [3:0] s);
    btn_raw = b;
    sw      = s;
    @(posedge clk);
    edge_no++;
    model_edge();
    #1;
    compare_outputs();
  endtask

  // Assert reset between edges, check outputs cleared with no clock, then
  // release on the falling edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_step",        step,        1'b0);
    check("rst_btn_level",   btn_level,   1'b0);
    check("rst_sw_latched",  sw_latched,  4'h0);
    check("rst_press_count", press_count, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    prev_level = 1'b0;
  endtask

  task automatic start_phase();
    edge_no         = 0;
    step_seen       = 0;
    last_step_edge  = -1;
    level_fall_edge = -1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic bounce_press[7];
    logic bounce_rel[8];
    int   seg_len;
    logic target;

    bounce_press = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bounce_rel   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    reset   = 1'b1;
    btn_raw = 1'b0;
    sw      = 4'h0;
    prev_level = 1'b0;
    start_phase();
    do_reset();

    // Clean press with sw=1010 held 20 cycles.
    start_phase();
    for (int i = 0; i < 20; i++) tick(1'b1, 4'b1010);
    check("t1_step_edge",   last_step_edge, 7);
    check("t1_step_count",  step_seen,      1);
    check("t1_press_count", press_count,    8'd1);
    check("t1_sw_latched",  sw_latched,     4'b1010);
    check("t1_btn_level",   btn_level,      1'b1);

    // Clean release: level drops on edge D+3.
    start_phase();
    for (int i = 0; i < 12; i++) tick(1'b0, 4'b1010);
    check("t1_release_edge", level_fall_edge, 7);
    check("t1_release_steps", step_seen, 0);

    // Bouncing press, then stable high.
    do_reset();
    start_phase();
    foreach (bounce_press[i]) tick(bounce_press[i], 4'h6);
    for (int i = 0; i < 15; i++) tick(1'b1, 4'h6);
    check("t2_step_count",  step_seen,      1);
    check("t2_step_edge",   last_step_edge, 14);
    check("t2_press_count", press_count,    8'd1);

    // Release with high glitches inside the release window.
    start_phase();
    foreach (bounce_rel[i]) tick(bounce_rel[i], 4'h6);
    for (int i = 0; i < 12; i++) tick(1'b0, 4'h6);
    check("t3_step_count",  step_seen,       0);
    check("t3_fall_edge",   level_fall_edge, 14);
    check("t3_press_count", press_count,     8'd1);

    // Reset while HELD, button stays held through reset.
    do_reset();
    for (int i = 0; i < 10; i++) tick(1'b1, 4'h9);
    check("t4_held_level", btn_level, 1'b1);
    btn_raw = 1'b1;
    do_reset();
    start_phase();
    for (int i = 0; i < 12; i++) tick(1'b1, 4'h9);
    check("t4_step_edge",   last_step_edge, 7);
    check("t4_step_count",  step_seen,      1);
    check("t4_press_count", press_count,    8'd1);
    for (int i = 0; i < 10; i++) tick(1'b0, 4'h9);

    // 256 clean presses wrap the press counter back to zero.
    btn_raw = 1'b0;
    do_reset();
    start_phase();
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < D + 5; i++) tick(1'b1, 4'(p));
      for (int i = 0; i < D + 5; i++) tick(1'b0, 4'(p));
    end
    check("t5_step_count",  step_seen,   256);
    check("t5_press_count", press_count, 8'h00);

    // Switch changes while held after a step do not disturb sw_latched.
    do_reset();
    for (int i = 0; i < 10; i++) tick(1'b1, 4'h5);
    for (int i = 0; i < 5; i++)  tick(1'b1, 4'h0);
    for (int i = 0; i < 5; i++)  tick(1'b1, 4'hF);
    for (int i = 0; i < 5; i++)  tick(1'b1, 4'h3);
    check("t6_hold_sw", sw_latched, 4'h5);
    for (int i = 0; i < 10; i++) tick(1'b0, 4'h3);
    check("t6_release_sw", sw_latched, 4'h5);
    for (int i = 0; i < 10; i++) tick(1'b1, 4'h3);
    check("t6_next_sw",    sw_latched,  4'h3);
    check("t6_press_count", press_count, 8'd2);

    // Randomised segments: each segment aims at a level and injects bounce.
    for (int seg = 0; seg < 300; seg++) begin
      target  = 1'($urandom_range(0, 1));
      seg_len = $urandom_range(1, 14);
      for (int i = 0; i < seg_len; i++) begin
        tick(($urandom_range(0, 9) < 2) ? ~target : target,
             4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 49) == 0) do_reset();
    end
    for (int i = 0; i < 12; i++) tick(1'b0, 4'h0);

    check("sb_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
